systolic_result_drain: RTL and testbench

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_result_drain.sv | 112 +++++++++++
 tb/tb_systolic_result_drain.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - captures a systolic result matrix and streams it out one element per handshake
// Optional res_parity output enabled by defining SYSTOLIC_DRAIN_PARITY_EN.
module systolic_result_drain #(
    parameter int DIM = 4,
    parameter int DATA_W = 32,
    localparam int N = DIM * DIM,
    localparam int IDX_W = $clog2(DIM * DIM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N*DATA_W-1:0]   y_in,
    input  logic                  done_matrix_mult,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic [IDX_W-1:0]      res_index,
    output logic                  res_last,
    output logic                  busy,
    output logic                  frame_done,
`ifdef SYSTOLIC_DRAIN_PARITY_EN
    output logic                  res_parity,
`endif
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t            state;
    state_t            state_next;
    logic              done_q;
    logic              rise;
    logic              capture;
    logic              xfer;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] buffer [N];

    assign rise = done_matrix_mult & ~done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_matrix_mult;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        xfer       = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                res_valid = 1'b1;
                busy      = 1'b1;
                xfer      = res_ready;
                if (res_ready && index == LAST_IDX) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Index saturates on the last element so it never wraps inside a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            index   <= '0;
            overrun <= 1'b0;
            for (int k = 0; k < N; k++) begin
                buffer[k] <= '0;
            end
        end else begin
            if (capture) begin
                index <= '0;
                for (int k = 0; k < N; k++) begin
                    buffer[k] <= y_in[(N-k)*DATA_W-1 -: DATA_W];
                end
            end else if (xfer && index != LAST_IDX) begin
                index <= index + 1'b1;
            end
            if (rise && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    assign res_data  = res_valid ? buffer[index] : '0;
    assign res_index = res_valid ? index : '0;
    assign res_last  = res_valid && (index == LAST_IDX);

`ifdef SYSTOLIC_DRAIN_PARITY_EN
    assign res_parity = ^res_data;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - scoreboard bench for systolic_result_drain
// Parity checks compile in when SYSTOLIC_DRAIN_PARITY_EN is defined.
module tb_systolic_result_drain;

    localparam int DIM = 4;
    localparam int DATA_W = 32;
    localparam int N = DIM * DIM;

    logic                clk = 1'b0;
    logic                reset;
    logic [N*DATA_W-1:0] y_in;
    logic                done_matrix_mult;
    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_data;
    logic [3:0]          res_index;
    logic                res_last;
    logic                busy;
    logic                frame_done;
    logic                overrun;
`ifdef SYSTOLIC_DRAIN_PARITY_EN
    logic                res_parity;
`endif

    typedef struct {
        logic [31:0] data;
        int          idx;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_total = 0;
    bit   fd_prev = 1'b0;

    systolic_result_drain #(.DIM(DIM), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .y_in             (y_in),
        .done_matrix_mult (done_matrix_mult),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_index        (res_index),
        .res_last         (res_last),
        .busy             (busy),
        .frame_done       (frame_done),
`ifdef SYSTOLIC_DRAIN_PARITY_EN
        .res_parity       (res_parity),
`endif
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            fd_prev = 1'b0;
        end else begin
            if (res_valid) begin
                check_val("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_val("res_data", res_data, exp_q[0].data);
                    check_val("res_index", res_index, exp_q[0].idx);
                    check_val("res_last", res_last, exp_q[0].last);
                    check_val("busy_stream", busy, 1);
`ifdef SYSTOLIC_DRAIN_PARITY_EN
                    check_val("res_parity", res_parity, ^exp_q[0].data);
`endif
                    if (res_ready) void'(exp_q.pop_front());
                end
            end else begin
                check_val("idle_data", res_data, 0);
`ifdef SYSTOLIC_DRAIN_PARITY_EN
                check_val("idle_parity", res_parity, 0);
`endif
            end
            if (frame_done) begin
                fd_total++;
                check_val("fd_single", fd_prev, 0);
                check_val("fd_q_empty", exp_q.size(), 0);
                check_val("fd_busy", busy, 0);
            end
            fd_prev = frame_done;
        end
    end

    // Element k holds base+k+1; y_in is scrambled right after capture.
    task automatic stream_frame(input bit alt, input bit hold_done, input int ovr_at, input int base);
        int vcount;
        int fd_cycle;
        int exp_valid;
        exp_valid = alt ? 2 * N - 1 : N;
        vcount = 0;
        fd_cycle = -1;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            y_in[(N-k)*DATA_W-1 -: DATA_W] = base + k + 1;
            exp_q.push_back('{data: base + k + 1, idx: k, last: (k == N - 1)});
        end
        res_ready = 1'b1;
        done_matrix_mult = 1'b1;
        for (int i = 1; i <= 100 && fd_cycle < 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                for (int k = 0; k < N; k++) y_in[(N-k)*DATA_W-1 -: DATA_W] = $urandom;
                if (!hold_done) done_matrix_mult = 1'b0;
            end
            if (ovr_at >= 0 && i == ovr_at + 1) done_matrix_mult = 1'b1;
            if (ovr_at >= 0 && i == ovr_at + 2) done_matrix_mult = 1'b0;
            res_ready = alt ? (vcount % 2 == 0) : 1'b1;
            @(negedge clk);
            if (res_valid) vcount++;
            if (frame_done) fd_cycle = i;
        end
        check_val("valid_cycles", vcount, exp_valid);
        check_val("fd_cycle", fd_cycle, exp_valid + 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int vc;
        int fd_before;
        reset = 1'b1;
        done_matrix_mult = 1'b0;
        res_ready = 1'b0;
        y_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_valid", res_valid, 0);
        check_val("rst_data", res_data, 0);
        check_val("rst_index", res_index, 0);
        check_val("rst_last", res_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_overrun", overrun, 0);

        stream_frame(1'b0, 1'b0, -1, 0);
        check_val("no_overrun", overrun, 0);
        // Starts right after FINISH so the rise lands in the first IDLE cycle.
        stream_frame(1'b1, 1'b0, -1, 16);

        stream_frame(1'b0, 1'b0, 5, 32);
        check_val("overrun_set", overrun, 1);
        repeat (4) @(posedge clk);
        stream_frame(1'b0, 1'b0, -1, 48);
        check_val("overrun_sticky", overrun, 1);

        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            y_in[(N-k)*DATA_W-1 -: DATA_W] = 200 + k + 1;
            exp_q.push_back('{data: 200 + k + 1, idx: k, last: (k == N - 1)});
        end
        res_ready = 1'b1;
        done_matrix_mult = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 7; i++) begin
            @(posedge clk); #1;
            done_matrix_mult = 1'b0;
            @(negedge clk);
            if (res_valid && res_ready) n++;
        end
        check_val("pre_reset_xfers", n, 7);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        fd_before = fd_total;
        @(negedge clk);
        check_val("mid_rst_valid", res_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_fd", frame_done, 0);
        check_val("mid_rst_overrun", overrun, 0);
        repeat (5) @(negedge clk);
        check_val("no_fd_after_reset", fd_total, fd_before);
        stream_frame(1'b0, 1'b0, -1, 64);

        stream_frame(1'b0, 1'b1, -1, 80);
        vc = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) vc++;
        end
        check_val("hold_no_recapture", vc, 0);
        check_val("hold_busy", busy, 0);
        check_val("hold_overrun", overrun, 0);
        done_matrix_mult = 1'b0;
        stream_frame(1'b0, 1'b0, -1, 96);

        stream_frame(1'b0, 1'b0, -1, 2);

        @(negedge clk);
        check_val("final_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
